// File: rtl/stb_sampler.sv
// Strobe sampler: counts comparator hits on synchronised strobe rising edges over n strobes.
// Latency: strobe edge to count update is SYNC_STAGES+1 clk; result is held in DONE until res_ready_i.
// Backpressure: res_valid_o stays high with stable outputs until res_ready_i; optional STB_SAMPLER_PERIOD_EN adds period min/max.
module stb_sampler #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             stb_i,
  input  logic             cmp_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_samples_i,
  input  logic [TO_W-1:0]  timeout_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] ones_o,
  output logic [CNT_W-1:0] total_o,
`ifdef STB_SAMPLER_PERIOD_EN
  output logic [TO_W-1:0]  per_min_o,
  output logic [TO_W-1:0]  per_max_o,
`endif
  output logic             err_timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACC, S_DONE} state_t;

  state_t                 state;
  logic [1:0]             rst_pipe;
  logic                   rst;
  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] cmp_sync;
  logic                   stb_d;
  logic                   stb_rise;
  logic                   cmp_s;
  logic [CNT_W-1:0]       n_lat;
  logic [TO_W-1:0]        to_lat;
  logic [TO_W-1:0]        to_cnt;
  logic [TO_W-1:0]        to_cnt_inc;
  logic [TO_W-1:0]        gap;
  logic                   to_hit;
  logic [CNT_W-1:0]       total_nxt;

  // Reset asserts immediately with arst_i and releases two clocks after it drops.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) rst_pipe <= 2'b11;
    else        rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  // Equal-depth synchronisers keep cmp aligned with the strobe it belongs to.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      stb_sync <= '0;
      cmp_sync <= '0;
      stb_d    <= 1'b0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], stb_i};
      cmp_sync <= {cmp_sync[SYNC_STAGES-2:0], cmp_i};
      stb_d    <= stb_sync[SYNC_STAGES-1];
    end
  end

  assign stb_rise   = stb_sync[SYNC_STAGES-1] & ~stb_d;
  assign cmp_s      = cmp_sync[SYNC_STAGES-1];
  assign to_cnt_inc = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
  assign gap        = to_cnt + TO_W'(1);
  assign to_hit     = (to_lat != '0) && (gap == to_lat);
  assign total_nxt  = total_o + CNT_W'(1);

  // Run-control FSM with registered result outputs; an edge beats a same-cycle timeout.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      busy_o        <= 1'b0;
      res_valid_o   <= 1'b0;
      ones_o        <= '0;
      total_o       <= '0;
      err_timeout_o <= 1'b0;
      n_lat         <= '0;
      to_lat        <= '0;
      to_cnt        <= '0;
`ifdef STB_SAMPLER_PERIOD_EN
      per_min_o     <= '0;
      per_max_o     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            n_lat         <= n_samples_i;
            to_lat        <= timeout_i;
            ones_o        <= '0;
            total_o       <= '0;
            err_timeout_o <= 1'b0;
            to_cnt        <= '0;
`ifdef STB_SAMPLER_PERIOD_EN
            per_min_o     <= '1;
            per_max_o     <= '0;
`endif
            if (n_samples_i == '0) begin
              state       <= S_DONE;
              res_valid_o <= 1'b1;
            end else begin
              state  <= S_ARM;
              busy_o <= 1'b1;
            end
          end
        end
        S_ARM: begin
          // First edge only aligns phase; it is never counted.
          if (stb_rise) begin
            to_cnt <= '0;
            state  <= S_ACC;
          end else if (to_hit) begin
            err_timeout_o <= 1'b1;
            busy_o        <= 1'b0;
            res_valid_o   <= 1'b1;
            state         <= S_DONE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_ACC: begin
          if (stb_rise) begin
            to_cnt  <= '0;
            total_o <= total_nxt;
            ones_o  <= ones_o + CNT_W'(cmp_s);
`ifdef STB_SAMPLER_PERIOD_EN
            // A period needs a previous counted edge, so skip the first one.
            if (total_o != '0) begin
              if (gap < per_min_o) per_min_o <= gap;
              if (gap > per_max_o) per_max_o <= gap;
            end
`endif
            if (total_nxt == n_lat) begin
              busy_o      <= 1'b0;
              res_valid_o <= 1'b1;
              state       <= S_DONE;
            end
          end else if (to_hit) begin
            err_timeout_o <= 1'b1;
            busy_o        <= 1'b0;
            res_valid_o   <= 1'b1;
            state         <= S_DONE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
